// File: rtl/serial_adder_pipe.sv
// serial_adder_pipe: WIDTH-bit add/subtract computed CHUNK bits per clock through a CHUNK-wide ripple.
// Latency: out_valid rises WIDTH/CHUNK cycles after the accepting edge; one op per N+2 cycles.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is seen.
module serial_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("serial_adder_pipe: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;   // already inverted for subtract
  logic             carry;

  logic [CHUNK-1:0] chunk_sum;
  logic [CHUNK:0]   chain;  // chain[i] = carry into bit i of the current chunk
  logic [WIDTH-1:0] sum_shift;

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Ripple the low CHUNK bits of the remaining operands with the running carry.
  always_comb begin
    chain     = '0;
    chunk_sum = '0;
    chain[0]  = carry;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_sum[i] = a_q[i] ^ b_q[i] ^ chain[i];
      chain[i+1]   = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // New chunk enters at the MSB end; after N chunks the first one sits at the LSB.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign sum_shift = chunk_sum;
    end else begin : g_multi
      assign sum_shift = {chunk_sum, sum[WIDTH-1:CHUNK]};
    end
  endgenerate

  // Control FSM and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_shift;
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          carry <= chain[CHUNK];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Final chunk holds the word MSB: overflow is carry-in vs carry-out of it.
            cout  <= chain[CHUNK];
            ovf   <= chain[CHUNK] ^ chain[CHUNK-1];
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_pipe.sv
`timescale 1ns/1ps
module tb_serial_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Arithmetic meaning of the operation, from plain integer math.
  function automatic void ref_add(input int w, input longint ua, input longint ub,
                                  input bit ci, input bit sb,
                                  output longint s, output bit co, output bit ov);
    longint m, half, sa, sbv, r;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (ua >= half) ? ua - m : ua;
    sbv  = (ub >= half) ? ub - m : ub;
    r    = sb ? (sa - sbv - longint'(ci)) : (sa + sbv + longint'(ci));
    ov   = (r >= half) || (r < -half);
    if (sb) begin
      co = (ua >= ub + longint'(ci));
      s  = (ua - ub - longint'(ci)) & (m - 1);
    end else begin
      co = ((ua + ub + longint'(ci)) >= m);
      s  = (ua + ub + longint'(ci)) & (m - 1);
    end
  endfunction

  // ---------------- directed instance, WIDTH=16 CHUNK=4 ----------------
  logic        d_rst_n, d_in_valid, d_in_ready, d_cin, d_sub;
  logic        d_out_valid, d_out_ready, d_cout, d_ovf;
  logic [15:0] d_a, d_b, d_sum;

  serial_adder_pipe #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(d_rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int lat;
    lat = 0;
    while (!d_out_valid && lat < 20) begin
      chk({nm, "_in_ready_busy"}, longint'(d_in_ready), 0);
      tick();
      lat++;
    end
    chk({nm, "_latency"}, longint'(lat), 4);
  endtask

  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input bit ci, input bit sb,
                        input logic [15:0] es, input bit eco, input bit eov);
    longint ms;
    bit     mco, mov;
    ref_add(16, longint'(a), longint'(b), ci, sb, ms, mco, mov);
    chk({nm, "_model_sum"}, ms, longint'(es));
    chk({nm, "_model_cout"}, longint'(mco), longint'(eco));
    chk({nm, "_model_ovf"}, longint'(mov), longint'(eov));
    d_a = a; d_b = b; d_cin = ci; d_sub = sb; d_in_valid = 1'b1;
    tick();
    d_in_valid = 1'b0;
    wait_done(nm);
    chk({nm, "_sum"}, longint'(d_sum), longint'(es));
    chk({nm, "_cout"}, longint'(d_cout), longint'(eco));
    chk({nm, "_ovf"}, longint'(d_ovf), longint'(eov));
    chk({nm, "_in_ready_done"}, longint'(d_in_ready), 0);
    d_out_ready = 1'b1;
    tick();
    d_out_ready = 1'b0;
    chk({nm, "_out_valid_taken"}, longint'(d_out_valid), 0);
    chk({nm, "_in_ready_idle"}, longint'(d_in_ready), 1);
  endtask

  initial begin
    d_rst_n = 1'b0; d_in_valid = 1'b0; d_a = '0; d_b = '0;
    d_cin = 1'b0; d_sub = 1'b0; d_out_ready = 1'b0;
    #12;
    chk("rst_out_valid", longint'(d_out_valid), 0);
    chk("rst_in_ready", longint'(d_in_ready), 1);
    chk("rst_sum", longint'(d_sum), 0);
    chk("rst_cout", longint'(d_cout), 0);
    chk("rst_ovf", longint'(d_ovf), 0);
    d_rst_n = 1'b1;
    tick();

    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("cin_wrap",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_cin",   16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

    // Backpressure: result must hold and new operands must be ignored.
    d_a = 16'h00F0; d_b = 16'h0F0F; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1;
    tick();
    d_in_valid = 1'b0;
    wait_done("bp_first");
    for (int i = 0; i < 5; i++) begin
      d_in_valid = (i % 2 == 0);
      d_a = 16'($urandom); d_b = 16'($urandom);
      d_cin = 1'($urandom); d_sub = 1'($urandom);
      tick();
      chk("bp_hold_sum", longint'(d_sum), 16'h0FFF);
      chk("bp_hold_cout", longint'(d_cout), 0);
      chk("bp_hold_ovf", longint'(d_ovf), 0);
      chk("bp_hold_out_valid", longint'(d_out_valid), 1);
      chk("bp_hold_in_ready", longint'(d_in_ready), 0);
    end
    d_a = 16'h8000; d_b = 16'h8001; d_cin = 1'b0; d_sub = 1'b0;
    d_in_valid = 1'b1; d_out_ready = 1'b1;
    tick();
    d_out_ready = 1'b0;
    chk("bp_release_in_ready", longint'(d_in_ready), 1);
    chk("bp_release_out_valid", longint'(d_out_valid), 0);
    tick();
    d_in_valid = 1'b0;
    wait_done("bp_next");
    chk("bp_next_sum", longint'(d_sum), 16'h0001);
    chk("bp_next_cout", longint'(d_cout), 1);
    chk("bp_next_ovf", longint'(d_ovf), 1);
    d_out_ready = 1'b1;
    tick();
    d_out_ready = 1'b0;

    // Reset in the middle of RUN clears outputs without any clock edge.
    d_a = 16'hABCD; d_b = 16'h1111; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1;
    tick();
    d_in_valid = 1'b0;
    tick();
    tick();
    #2 d_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(d_out_valid), 0);
    chk("midrst_sum", longint'(d_sum), 0);
    chk("midrst_cout", longint'(d_cout), 0);
    chk("midrst_ovf", longint'(d_ovf), 0);
    chk("midrst_in_ready", longint'(d_in_ready), 1);
    #3 d_rst_n = 1'b1;
    tick();
    chk("postrst_in_ready", longint'(d_in_ready), 1);
    run_op("postrst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    n_done++;
  end

  // ---------------- randomized instances against the model ----------------
  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int W = (g == 3) ? 8 : 16;
    localparam int C = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 2;
    localparam int N = W / C;

    logic         r_rst_n, r_in_valid, r_in_ready, r_cin, r_sub;
    logic         r_out_valid, r_out_ready, r_cout, r_ovf;
    logic [W-1:0] r_a, r_b, r_sum;

    serial_adder_pipe #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk(clk), .rst_n(r_rst_n), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .a(r_a), .b(r_b), .cin(r_cin), .sub(r_sub),
      .out_valid(r_out_valid), .out_ready(r_out_ready),
      .sum(r_sum), .cout(r_cout), .ovf(r_ovf)
    );

    initial begin
      longint cyc, acc, es;
      int     ops;
      bit     pend, eco, eov, due;
      cyc = 0; acc = 0; es = 0; ops = 0; pend = 1'b0; eco = 1'b0; eov = 1'b0;
      r_rst_n = 1'b0; r_in_valid = 1'b0; r_a = '0; r_b = '0;
      r_cin = 1'b0; r_sub = 1'b0; r_out_ready = 1'b0;
      #12 r_rst_n = 1'b1;
      @(posedge clk);
      #1;
      while (ops < 1000 && cyc < 40000) begin
        due = pend && (cyc - acc >= longint'(N));
        chk($sformatf("rnd%0d_in_ready", g), longint'(r_in_ready), longint'(!pend));
        chk($sformatf("rnd%0d_out_valid", g), longint'(r_out_valid), longint'(due));
        if (due) begin
          chk($sformatf("rnd%0d_sum", g), longint'(r_sum), es);
          chk($sformatf("rnd%0d_cout", g), longint'(r_cout), longint'(eco));
          chk($sformatf("rnd%0d_ovf", g), longint'(r_ovf), longint'(eov));
        end
        r_in_valid  = ($urandom_range(3) != 0);
        r_out_ready = ($urandom_range(3) != 0);
        r_a   = W'($urandom);
        r_b   = W'($urandom);
        r_cin = 1'($urandom);
        r_sub = 1'($urandom);
        if (!pend && r_in_valid) begin
          ref_add(W, longint'(r_a), longint'(r_b), r_cin, r_sub, es, eco, eov);
          pend = 1'b1;
          acc  = cyc + 1;
        end else if (due && r_out_ready) begin
          pend = 1'b0;
          ops++;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      chk($sformatf("rnd%0d_ops_completed", g), longint'(ops), 1000);
      n_done++;
    end
  end

  initial begin
    fork
      wait (n_done == 5);
      #600000;
    join_any
    chk("all_processes_done", longint'(n_done), 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
